// File: rtl/sw_pkg.sv
// Shared types and default parameters for the slide-switch conditioner.
// The FSM encoding lives here so the top level and any future consumers agree on it.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_LOW = 2'd2
  } sw_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_SW_W            = 10;
  localparam int DEF_DATA_W          = 8;
  localparam int DEF_STROBE_BIT      = 8;

  // A one-cycle debounce still needs a 1-bit counter to keep the port width legal.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a saturating-compare debouncer.
// The clean value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sw_debounce_bit
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic clean
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;

  always_comb begin
    s1_d    = sw_in;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    // Any sample agreeing with the clean value restarts the run, so glitches never accumulate.
    if (s2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/sw_conditioner.sv
// Switch front end: per-bit debounce, strobe edge detect and a valid/ack byte holder.
// Each clean strobe rise is captured once; rises while a byte is still held set a sticky overrun.
module sw_conditioner
  import sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SW_W            = DEF_SW_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int STROBE_BIT      = DEF_STROBE_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SW_W-1:0]   SW,
  input  logic              ack,
  output logic [SW_W-1:0]   sw_clean,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              overrun
);

  genvar gi;
  generate
    for (gi = 0; gi < SW_W; gi++) begin : g_bit
      sw_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk   (clk),
        .reset (reset),
        .sw_in (SW[gi]),
        .clean (sw_clean[gi])
      );
    end
  endgenerate

  sw_state_t         state_q, state_d;
  logic              strobe_q, strobe_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              strobe_rise;

  assign strobe_rise = sw_clean[STROBE_BIT] & ~strobe_q;

  always_comb begin
    state_d   = state_q;
    strobe_d  = sw_clean[STROBE_BIT];
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (strobe_rise) begin
          data_d  = sw_clean[DATA_W-1:0];
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The held byte stays frozen; a fresh rise only raises the overrun flag.
        if (strobe_rise) begin
          overrun_d = 1'b1;
        end
        if (ack) begin
          valid_d = 1'b0;
          state_d = sw_clean[STROBE_BIT] ? WAIT_LOW : IDLE;
        end
      end
      WAIT_LOW: begin
        if (!sw_clean[STROBE_BIT]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      strobe_q  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: expected capture bytes are queued when the strobe is driven
// and compared by a monitor whenever data_valid rises.
module tb_sw_conditioner;

  localparam int STB = 8;

  logic       clk;
  logic       reset;
  logic [9:0] SW;
  logic       ack;
  logic [9:0] sw_clean;
  logic [7:0] data;
  logic       data_valid;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  sw_conditioner dut (
    .clk        (clk),
    .reset      (reset),
    .SW         (SW),
    .ack        (ack),
    .sw_clean   (sw_clean),
    .data       (data),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clean8(input logic lvl, input string tag);
    int n = 0;
    while (sw_clean[STB] !== lvl && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(sw_clean[STB]), 32'(lvl));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (data_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(data_valid), 32'd1);
  endtask

  // Capture monitor: every rise of data_valid must match the next queued byte.
  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_capture", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        $display("capture data=0x%02h expected=0x%02h", data, e);
        check_eq("capture_data", 32'(data), 32'(e));
      end
    end
    prev_valid = data_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    SW    = 10'h000;
    ack   = 1'b0;
    repeat (3) tick();
    check_eq("rst_sw_clean", 32'(sw_clean), 32'h0);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_valid", 32'(data_valid), 32'h0);
    check_eq("rst_overrun", 32'(overrun), 32'h0);

    // Debounce latency: visible after the fifth edge only.
    reset = 1'b0;
    SW    = 10'h0A5;
    for (int e = 0; e < 4; e++) begin
      tick();
      check_eq("deb_before", 32'(sw_clean), 32'h0);
    end
    tick();
    check_eq("deb_after", 32'(sw_clean), 32'h0A5);
    check_eq("deb_valid", 32'(data_valid), 32'h0);

    // Two-edge glitch on bit 3 must be rejected.
    SW = 10'h0AD;
    for (int e = 0; e < 2; e++) begin
      tick();
      check_eq("glitch_bit3", 32'(sw_clean[3]), 32'h0);
    end
    SW = 10'h0A5;
    for (int e = 0; e < 8; e++) begin
      tick();
      check_eq("glitch_bit3", 32'(sw_clean[3]), 32'h0);
    end

    // Single capture, ack, then long strobe hold with no recapture.
    SW = 10'h03C;
    repeat (6) tick();
    SW = 10'h13C;
    exp_q.push_back(8'h3C);
    wait_clean8(1'b1, "cap_strobe_seen");
    check_eq("cap_valid_pre", 32'(data_valid), 32'h0);
    tick();
    check_eq("cap_valid", 32'(data_valid), 32'h1);
    check_eq("cap_data", 32'(data), 32'h3C);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("cap_ack_valid", 32'(data_valid), 32'h0);
    repeat (20) tick();
    check_eq("no_second_capture", 32'(data_valid), 32'h0);

    // Overrun: second rise while the first byte is still held.
    SW = 10'h011;
    wait_clean8(1'b0, "ovr_strobe_low0");
    SW = 10'h111;
    exp_q.push_back(8'h11);
    wait_valid("ovr_cap_valid");
    SW = 10'h022;
    wait_clean8(1'b0, "ovr_strobe_low1");
    SW = 10'h122;
    wait_clean8(1'b1, "ovr_strobe_high1");
    tick();
    check_eq("ovr_flag", 32'(overrun), 32'h1);
    check_eq("ovr_data_frozen", 32'(data), 32'h11);
    check_eq("ovr_valid_held", 32'(data_valid), 32'h1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ovr_ack_valid", 32'(data_valid), 32'h0);
    check_eq("ovr_sticky", 32'(overrun), 32'h1);

    // Simultaneous ack and rise in HOLD.
    SW    = 10'h033;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("sim_rst_overrun", 32'(overrun), 32'h0);
    repeat (6) tick();
    SW = 10'h133;
    exp_q.push_back(8'h33);
    wait_valid("sim_cap_valid");
    SW = 10'h033;
    wait_clean8(1'b0, "sim_strobe_low");
    SW = 10'h133;
    wait_clean8(1'b1, "sim_strobe_high");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("sim_valid", 32'(data_valid), 32'h0);
    check_eq("sim_overrun", 32'(overrun), 32'h1);
    check_eq("sim_data", 32'(data), 32'h33);

    // Reset mid-handshake with the strobe held high through reset.
    SW = 10'h044;
    wait_clean8(1'b0, "rmh_strobe_low");
    SW = 10'h144;
    exp_q.push_back(8'h44);
    wait_valid("rmh_cap_valid");
    reset = 1'b1;
    tick();
    check_eq("rmh_sw_clean", 32'(sw_clean), 32'h0);
    check_eq("rmh_data", 32'(data), 32'h0);
    check_eq("rmh_valid", 32'(data_valid), 32'h0);
    check_eq("rmh_overrun", 32'(overrun), 32'h0);
    exp_q.push_back(8'h44);
    reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      tick();
      check_eq("rmh_valid_early", 32'(data_valid), 32'h0);
    end
    tick();
    check_eq("rmh_recap_valid", 32'(data_valid), 32'h1);
    check_eq("rmh_recap_data", 32'(data), 32'h44);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (20) tick();
    check_eq("rmh_single_recap", 32'(data_valid), 32'h0);
    check_eq("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sw_conditioner.md
# sw_conditioner

Input front end between the DE-board slide switches and the picoMIPS core, clocked by the same slow clock. It synchronises and debounces SW[9:0] and presents a clean switch image. On a rising edge of a designated strobe switch it latches a data byte and holds it under a valid/ack handshake, so each strobe is consumed exactly once. It flags strobes that arrive before the previous byte was acknowledged.

## Interface
- DEBOUNCE_CYCLES, 3: consecutive synchronised samples that must differ from the clean value before it flips (≥1).
- SW_W, 10: switch count.
- DATA_W, 8: captured data width; the captured field is sw_clean[DATA_W-1:0].
- STROBE_BIT, 8: index of the strobe switch (≥ DATA_W, < SW_W).
- clk  in  1  system clock (slow core clock).
- reset  in  1  synchronous, active-high reset.
- SW  in  SW_W  raw, asynchronous switch inputs.
- ack  in  1  consumer acknowledge of the held byte.
- sw_clean  out  SW_W  debounced switch image.
- data  out  DATA_W  byte latched at the strobe rise.
- data_valid  out  1  data held, awaiting ack.
- overrun  out  1  sticky: strobe rise seen while data_valid was high.

## Operation
- Synchroniser: two flops per bit (s1, s2), with no logic between them.
- Debounce, per bit i, using counter cnt[i] of width $clog2(DEBOUNCE_CYCLES):
  - If s2[i]==sw_clean[i], then cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1, then sw_clean[i]<=s2[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - A single glitch sample resets the count.
- strobe_q registers sw_clean[STROBE_BIT]. A rise is sw_clean[STROBE_BIT] & ~strobe_q.
- FSM states:
  - IDLE: on a rise, data<=sw_clean[DATA_W-1:0], data_valid<=1, go to HOLD.
  - HOLD: on ack, data_valid<=0. Then go to WAIT_LOW if sw_clean[STROBE_BIT]==1, else go to IDLE.
  - WAIT_LOW: go to IDLE when sw_clean[STROBE_BIT]==0.
- ack is ignored outside HOLD.
- While in HOLD, data is frozen.
- A rise in HOLD sets overrun and does not change data. If ack is also high on the same edge, ack is honoured and overrun is still set.
- overrun clears only on reset.
- Reset, applied on any edge including mid-handshake or mid-debounce: s1, s2, cnt, sw_clean, strobe_q, data, data_valid and overrun all go to 0, and the FSM goes to IDLE.
- A switch held high through reset re-appears after the debounce latency. A strobe held high through reset therefore produces one capture after reset; this is required behaviour.

## Timing
- SW change to sw_clean change: DEBOUNCE_CYCLES+2 rising edges (2 sync edges plus DEBOUNCE_CYCLES compare edges). With the default, 5 edges.
- sw_clean[STROBE_BIT] rise to data_valid high: 1 edge. Capture and valid are updated on the same edge.
- ack high at edge k, in HOLD: data_valid is low after edge k. A new capture is possible no earlier than the edge on which the strobe has been seen low and then high again.
- All outputs are registered. There is no combinational path from SW or ack to any output.

## Structure
- Shared package sw_pkg:
  - typedef enum logic [1:0] {IDLE, HOLD, WAIT_LOW} sw_state_t.
  - Default localparams for DEBOUNCE_CYCLES, SW_W, DATA_W and STROBE_BIT.
- Sub-module sw_debounce_bit holds one bit's s1/s2, counter and clean flop. It takes the DEBOUNCE_CYCLES parameter and is instantiated SW_W times with a generate loop.
- The top level holds strobe_q, the FSM, the data register and overrun.

## Test plan
- Debounce latency: reset, then set SW=10'h0A5 before edge 0 → sw_clean==10'h0A5 after edge 4, not before; data_valid stays 0.
- Glitch rejection: toggle SW[3] high for 2 edges only → sw_clean[3] stays 0 throughout.
- Single capture: SW=10'h03C, then raise SW[8] → data==8'h3C and data_valid=1 one edge after sw_clean[8] rises. Pulse ack for 1 cycle → data_valid=0. Keep SW[8] high for 20 edges → no second capture.
- Overrun: capture 8'h11 and withhold ack. Change to 8'h22, drop SW[8], raise it again → overrun=1, data stays 8'h11. Ack → data_valid=0, overrun remains 1.
- Simultaneous ack and rise in HOLD → data_valid=0 and overrun=1 after the same edge.
- Reset mid-handshake: assert reset while data_valid=1 → all outputs are 0 after that edge. With SW[8] still high, exactly one new capture occurs 6 edges after reset deasserts.
